// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   General-purpose register file for the single-cycle MIPS datapath.
//   Two asynchronous read ports (rs/rt operands), one synchronous write port
//   (write-back), register 0 hardwired to zero.
//
//   Ports:
//     clk              rising-edge clock
//     rst_n            asynchronous active-low reset; clears every entry
//     RegWrite         write enable from the control unit
//     Read_register_1  rs index
//     Read_register_2  rt index
//     Write_register   destination index (already selected by RegDst)
//     Write_data       write-back value
//     Read_data_1      contents of Read_register_1 (combinational)
//     Read_data_2      contents of Read_register_2 (combinational)
//
//   Build option:
//     REGFILE_BYPASS_EN  when defined, a same-cycle write to the addressed
//                        register is forwarded to the read port before the
//                        clock edge (per port, never for register 0).
// ---------------------------------------------------------------------------
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RegWrite,
   input  logic [ADDR_WIDTH-1:0] Read_register_1,
   input  logic [ADDR_WIDTH-1:0] Read_register_2,
   input  logic [ADDR_WIDTH-1:0] Write_register,
   input  logic [DATA_WIDTH-1:0] Write_data,
   output logic [DATA_WIDTH-1:0] Read_data_1,
   output logic [DATA_WIDTH-1:0] Read_data_2
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  wr_en_c;

   // A write to index 0 is dropped so entry 0 stays at its reset value.
   assign wr_en_c = RegWrite && (Write_register != ADDR_WIDTH'(0));

   // Storage: async clear, one write per edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en_c) begin
         regs[Write_register] <= Write_data;
      end
   end

   // Read ports: zero-latency lookup, index 0 forced to zero.
   always_comb begin
      Read_data_1 = '0;
      Read_data_2 = '0;
      if (Read_register_1 != ADDR_WIDTH'(0)) begin
         Read_data_1 = regs[Read_register_1];
      end
      if (Read_register_2 != ADDR_WIDTH'(0)) begin
         Read_data_2 = regs[Read_register_2];
      end
`ifdef REGFILE_BYPASS_EN
      // Write-through: the pending write wins over the stored value.
      // wr_en_c already excludes index 0; rst_n keeps reset reads at zero.
      if (rst_n && wr_en_c && (Write_register == Read_register_1)) begin
         Read_data_1 = Write_data;
      end
      if (rst_n && wr_en_c && (Write_register == Read_register_2)) begin
         Read_data_2 = Write_data;
      end
`endif
   end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk;
   logic          rst_n;
   logic          RegWrite;
   logic [AW-1:0] Read_register_1;
   logic [AW-1:0] Read_register_2;
   logic [AW-1:0] Write_register;
   logic [DW-1:0] Write_data;
   logic [DW-1:0] Read_data_1;
   logic [DW-1:0] Read_data_2;

   int vectors;
   int miscompares;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .RegWrite        (RegWrite),
      .Read_register_1 (Read_register_1),
      .Read_register_2 (Read_register_2),
      .Write_register  (Write_register),
      .Write_data      (Write_data),
      .Read_data_1     (Read_data_1),
      .Read_data_2     (Read_data_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RegWrite must never be unknown once out of reset.
   always @(posedge clk) begin
      if (rst_n === 1'b1 && $isunknown(RegWrite)) begin
         miscompares++;
         $display("FAIL regwrite_unknown: RegWrite=%b, required 0 or 1", RegWrite);
      end
   end

   // Single write: drive at negedge, commit on the following posedge.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      RegWrite       = 1'b1;
      Write_register = a;
      Write_data     = d;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic test_reset;
      // Reset state from power-up.
      rst_n = 1'b0; RegWrite = 1'b0; Write_register = '0; Write_data = '0;
      Read_register_1 = 5'd3; Read_register_2 = 5'd31;
      #12;
      vectors++;
      if (Read_data_1 !== 32'h0 || Read_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_initial: rd1=%h rd2=%h, required 0 0", Read_data_1, Read_data_2);
      end
      @(negedge clk); rst_n = 1'b1;
      // Preload, then verify values are present.
      do_write(5'd3, 32'hA5A5_A5A5);
      do_write(5'd31, 32'h5A5A_5A5A);
      @(negedge clk);
      #1;
      vectors++;
      if (Read_data_1 !== 32'hA5A5_A5A5 || Read_data_2 !== 32'h5A5A_5A5A) begin
         miscompares++;
         $display("FAIL reset_preload: rd1=%h rd2=%h, required a5a5a5a5 5a5a5a5a",
                  Read_data_1, Read_data_2);
      end
      // Pending write to r4, then reset asserted mid-cycle before the edge.
      RegWrite = 1'b1; Write_register = 5'd4; Write_data = 32'h0000_0044;
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (Read_data_1 !== 32'h0 || Read_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_async: rd1=%h rd2=%h, required 0 0", Read_data_1, Read_data_2);
      end
      @(posedge clk);
      @(negedge clk);
      RegWrite = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 32; i++) begin
         Read_register_1 = 5'(i);
         Read_register_2 = 5'(31 - i);
         #1;
         vectors++;
         if (Read_data_1 !== 32'h0 || Read_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_cleared r%0d/r%0d: rd1=%h rd2=%h, required 0 0",
                     i, 31 - i, Read_data_1, Read_data_2);
         end
      end
   endtask

   task automatic test_write_read;
      do_write(5'd5, 32'hDEAD_BEEF);
      Read_register_1 = 5'd5; Read_register_2 = 5'd5;
      #1;
      vectors++;
      if (Read_data_1 !== 32'hDEAD_BEEF || Read_data_2 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL write_r5: rd1=%h rd2=%h, required deadbeef deadbeef",
                  Read_data_1, Read_data_2);
      end
   endtask

   task automatic test_r0;
      @(negedge clk);
      Read_register_1 = 5'd0; Read_register_2 = 5'd0;
      RegWrite = 1'b1; Write_register = 5'd0; Write_data = 32'hFFFF_FFFF;
      #1;
      vectors++;
      if (Read_data_1 !== 32'h0 || Read_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL r0_pre_edge: rd1=%h rd2=%h, required 0 0", Read_data_1, Read_data_2);
      end
      @(posedge clk); #1;
      RegWrite = 1'b0;
      #1;
      vectors++;
      if (Read_data_1 !== 32'h0 || Read_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL r0_post_edge: rd1=%h rd2=%h, required 0 0", Read_data_1, Read_data_2);
      end
   endtask

   task automatic test_regwrite_off;
      @(negedge clk);
      Read_register_1 = 5'd9; Read_register_2 = 5'd9;
      RegWrite = 1'b0; Write_register = 5'd9; Write_data = 32'h1234_5678;
      #1;
      vectors++;
      if (Read_data_1 !== 32'h0 || Read_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL we_off_pre_edge: rd1=%h rd2=%h, required 0 0", Read_data_1, Read_data_2);
      end
      @(posedge clk); #1;
      vectors++;
      if (Read_data_1 !== 32'h0 || Read_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL we_off_post_edge: rd1=%h rd2=%h, required 0 0", Read_data_1, Read_data_2);
      end
   endtask

   task automatic test_same_cycle;
      logic [DW-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
      exp_pre = 32'h22;
`else
      exp_pre = 32'h11;
`endif
      do_write(5'd7, 32'h11);
      @(negedge clk);
      Read_register_1 = 5'd7; Read_register_2 = 5'd5;
      RegWrite = 1'b1; Write_register = 5'd7; Write_data = 32'h22;
      #1;
      vectors++;
      if (Read_data_1 !== exp_pre || Read_data_2 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL same_cycle_pre: rd1=%h rd2=%h, required %h deadbeef",
                  Read_data_1, Read_data_2, exp_pre);
      end
      @(posedge clk); #1;
      RegWrite = 1'b0;
      #1;
      vectors++;
      if (Read_data_1 !== 32'h22 || Read_data_2 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL same_cycle_post: rd1=%h rd2=%h, required 00000022 deadbeef",
                  Read_data_1, Read_data_2);
      end
   endtask

   task automatic test_sweep;
      logic [DW-1:0] e1, e2;
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i) * 32'h0101_0101);
      end
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 32; j++) begin
            Read_register_1 = 5'(i);
            Read_register_2 = 5'(j);
            e1 = 32'(i) * 32'h0101_0101;
            e2 = 32'(j) * 32'h0101_0101;
            #1;
            vectors++;
            if (Read_data_1 !== e1 || Read_data_2 !== e2) begin
               miscompares++;
               $display("FAIL sweep r%0d/r%0d: rd1=%h rd2=%h, required %h %h",
                        i, j, Read_data_1, Read_data_2, e1, e2);
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_write_read();
      test_r0();
      test_regwrite_off();
      test_same_cycle();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
